prog_clock_divider: RTL and testbench
=====================================

Name: prog_clock_divider

Overview:
- Runtime-programmable integer clock divider for the DDS clocking path.
- Produces a registered divided clock `clk_out` and a single-cycle `tick` enable at each period start.
- Divisor changes through a load strobe and take effect only at a period boundary, so output is glitch-free; `sync` re-phases several dividers together.
- Sits between the system clock and the DDS sample-rate / DAC-strobe logic.

Parameters:
- CNT_WIDTH, 16, width of divisor, counter and `cur_div`.
- DEFAULT_DIV, 2, active divisor after reset; must fit CNT_WIDTH.

Ports:
- clk_in  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; 0 freezes the divider.
- div_in  input  CNT_WIDTH  new divisor N.
- div_load  input  1  strobe; captures `div_in` into the pending register.
- sync  input  1  forces a period start on the next enabled edge.
- clk_out  output  1  divided clock, registered.
- tick  output  1  one-cycle pulse in the first cycle of each period.
- div_ack  output  1  one-cycle pulse when a pending divisor becomes active.
- pending  output  1  a loaded divisor is waiting to be applied.
- cur_div  output  CNT_WIDTH  active divisor.

Behaviour:
- Reset: clk_out=0, tick=0, div_ack=0, pending=0, cnt=0, cur_div=DEFAULT_DIV, pending value cleared. Reset mid-period abandons the period and discards the pending load.
- Down-counter cnt. Let H = floor(N/2) and N = cur_div.
- Start condition (N>=2): en=1 and (cnt==0 or sync=1). At that edge:
  - cnt<=N-1, clk_out<=1, tick<=1.
- Other enabled edges: cnt<=cnt-1, clk_out<=(cnt_next >= N-H), tick<=0.
- Result: clk_out is high for H cycles and low for N-H cycles, so odd N gives the longer low phase.
  - N=4 sequence: 1,1,0,0.
  - N=3 sequence: 1,0,0.
- First enabled edge after reset is a start edge, so tick rises one cycle after reset release with en=1.
- N=1: every enabled edge is a start; clk_out<=1 constantly; tick<=1 every enabled cycle.
- N=0 (idle): clk_out<=0, tick<=0, cnt held 0, sync ignored.
- en=0: cnt and clk_out hold; tick<=0, div_ack<=0. div_load is still captured.
- div_load: pending value<=div_in, pending<=1. A later load before application overwrites it (last wins).
- Application point: at a start edge (N>=1), if pending=1 and div_load is not asserted that edge, then:
  - cur_div<=pending value, pending<=0, div_ack<=1.
  - This same edge starts the new period with the new N: cnt<=Nnew-1 and clk_out per the new N.
- div_load coinciding with a start edge: the new value is captured, the old pending value (if any) is dropped, and nothing is applied that edge. Application waits for the next start.
- Idle exit: when cur_div==0 and pending=1, the next enabled edge applies the value and acts as a start edge for it.
- Loading 0 turns the divider idle at the next start edge; div_ack still pulses.
- sync together with pending: the pending value is applied at the sync-forced start.
- Width rules: cnt, cur_div and the pending value are CNT_WIDTH bits. N-1 and N-H are computed in CNT_WIDTH and never underflow for N>=1.

Decomposition:
- Package `clk_div_pkg`:
  - constants DIV_IDLE=0 and DIV_BYPASS=1;
  - function `hi_len(N)` returning floor(N/2);
  - function `clk_thresh(N)` returning N-hi_len(N).
- Sub-module `div_phase_counter`: loadable CNT_WIDTH down-counter with en, load and load value, plus a zero flag.
- Top level holds the divisor load/apply logic and output registers.

Test Plan:
- Reset release, en=1, DEFAULT_DIV=2 -> tick at cycle 1, then every 2 cycles; clk_out 1,0,1,0; cur_div=2.
- Load div_in=5 mid-period -> pending=1 until the next cnt==0 start; div_ack pulses once; clk_out becomes 1,1,0,0,0 repeating; tick every 5 cycles.
- Loads of 7 then 3 before a boundary -> only 3 is applied, with one div_ack; the 7 is never seen on cur_div.
- en=0 for 4 cycles at N=4 mid-high phase -> clk_out and cnt frozen, tick=0; the sequence resumes exactly where it stopped.
- Load 0 -> after the boundary clk_out=0 and tick=0 permanently; then load 1 -> next edge tick=1 every cycle with clk_out=1.
- Two instances at N=6 offset by 2 cycles, sync pulsed to both -> the next period starts on the same edge and ticks stay aligned. Also apply rst mid-period with pending=1 -> all outputs 0, cur_div=2, pending=0.

Source files
------------

// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared constants and helpers for the programmable clock
//               divider: idle/bypass divisor codes and phase split helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    // Width used by the helper functions; callers cast to their own width.
    localparam int unsigned FN_WIDTH   = 32;

    // Divisor 0 parks the divider; divisor 1 passes every enabled edge.
    localparam int unsigned DIV_IDLE   = 0;
    localparam int unsigned DIV_BYPASS = 1;

    // Number of high cycles in one period of divisor n.
    function automatic logic [FN_WIDTH-1:0] hi_len(input logic [FN_WIDTH-1:0] n);
        return n >> 1;
    endfunction

    // Counter value at or above which clk_out is high (n - floor(n/2)).
    function automatic logic [FN_WIDTH-1:0] clk_thresh(input logic [FN_WIDTH-1:0] n);
        return n - hi_len(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_phase_counter.sv
`default_nettype none
// ============================================================================
// Module      : div_phase_counter
// Description : Loadable down-counter tracking the position inside one
//               divider period, with a zero flag marking the period end.
// Revision    : 1.0 - initial release
// ============================================================================
module div_phase_counter
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 zero
);

    logic [CNT_WIDTH-1:0] r_cnt_q;
    logic [CNT_WIDTH-1:0] w_cnt_d;

    // Next count: reload at a period start, otherwise step down while enabled.
    always_comb begin
        w_cnt_d = r_cnt_q;
        if (en) begin
            if (load) begin
                w_cnt_d = load_val;
            end else begin
                w_cnt_d = r_cnt_q - CNT_WIDTH'(1);
            end
        end
    end

    // Count register.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign cnt  = r_cnt_q;
    assign zero = (r_cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/prog_clock_divider.sv
`default_nettype none
// ============================================================================
// Module      : prog_clock_divider
// Description : Runtime-programmable integer clock divider. Produces a
//               registered divided clock and a period-start tick; new
//               divisors are staged and applied only at a period boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_clock_divider
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_WIDTH   = 16,  // at most FN_WIDTH
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] div_in,
    input  logic                 div_load,
    input  logic                 sync,
    output logic                 clk_out,
    output logic                 tick,
    output logic                 div_ack,
    output logic                 pending,
    output logic [CNT_WIDTH-1:0] cur_div
);

    // Registered state
    logic [CNT_WIDTH-1:0] r_cur_div_q;
    logic [CNT_WIDTH-1:0] r_pend_val_q;
    logic                 r_pending_q;
    logic                 r_clk_out_q;
    logic                 r_tick_q;
    logic                 r_div_ack_q;

    // Next-state values
    logic [CNT_WIDTH-1:0] w_cur_div_d;
    logic [CNT_WIDTH-1:0] w_pend_val_d;
    logic                 w_pending_d;
    logic                 w_clk_out_d;
    logic                 w_tick_d;
    logic                 w_div_ack_d;

    // Period control
    logic [CNT_WIDTH-1:0] w_cnt;
    logic                 w_cnt_zero;
    logic [CNT_WIDTH-1:0] w_cnt_dec;
    logic [CNT_WIDTH-1:0] w_thresh;
    logic [CNT_WIDTH-1:0] w_n_eff;
    logic [CNT_WIDTH-1:0] w_load_val;
    logic                 w_idle;
    logic                 w_start;
    logic                 w_apply;
    logic                 w_cnt_load;

    assign w_idle     = (r_cur_div_q == CNT_WIDTH'(DIV_IDLE));
    assign w_cnt_dec  = w_cnt - CNT_WIDTH'(1);
    assign w_thresh   = CNT_WIDTH'(clk_thresh(FN_WIDTH'(r_cur_div_q)));

    // Decide whether this edge starts a period and whether the staged divisor
    // takes over. A load on the same edge wins, so nothing is applied then.
    always_comb begin
        w_start = 1'b0;
        w_apply = 1'b0;
        if (en) begin
            if (w_idle) begin
                // Leaving idle: the staged value acts as its own start edge.
                w_apply = r_pending_q & ~div_load;
                w_start = w_apply;
            end else begin
                w_start = w_cnt_zero | sync;
                w_apply = w_start & r_pending_q & ~div_load;
            end
        end
        w_n_eff    = w_apply ? r_pend_val_q : r_cur_div_q;
        // Divisors 0 and 1 keep the counter parked at zero.
        w_load_val = (w_n_eff <= CNT_WIDTH'(DIV_BYPASS)) ? '0 : (w_n_eff - CNT_WIDTH'(1));
        w_cnt_load = w_start | w_idle;
    end

    // Next values of the output, divisor and staging registers.
    always_comb begin
        w_clk_out_d  = r_clk_out_q;
        w_tick_d     = 1'b0;
        w_div_ack_d  = 1'b0;
        w_cur_div_d  = w_apply ? r_pend_val_q : r_cur_div_q;
        w_pend_val_d = div_load ? div_in : r_pend_val_q;
        w_pending_d  = r_pending_q;
        if (div_load) begin
            w_pending_d = 1'b1;
        end else if (w_apply) begin
            w_pending_d = 1'b0;
        end
        if (en) begin
            w_div_ack_d = w_apply;
            if (w_start) begin
                w_clk_out_d = (w_n_eff != '0);
                w_tick_d    = (w_n_eff != '0);
            end else if (w_idle) begin
                w_clk_out_d = 1'b0;
            end else begin
                w_clk_out_d = (w_cnt_dec >= w_thresh);
            end
        end
    end

    // Output and divisor registers.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_cur_div_q  <= CNT_WIDTH'(DEFAULT_DIV);
            r_pend_val_q <= '0;
            r_pending_q  <= 1'b0;
            r_clk_out_q  <= 1'b0;
            r_tick_q     <= 1'b0;
            r_div_ack_q  <= 1'b0;
        end else begin
            r_cur_div_q  <= w_cur_div_d;
            r_pend_val_q <= w_pend_val_d;
            r_pending_q  <= w_pending_d;
            r_clk_out_q  <= w_clk_out_d;
            r_tick_q     <= w_tick_d;
            r_div_ack_q  <= w_div_ack_d;
        end
    end

    div_phase_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_phase_cnt (
        .clk_in   (clk_in),
        .rst      (rst),
        .en       (en),
        .load     (w_cnt_load),
        .load_val (w_load_val),
        .cnt      (w_cnt),
        .zero     (w_cnt_zero)
    );

    assign clk_out = r_clk_out_q;
    assign tick    = r_tick_q;
    assign div_ack = r_div_ack_q;
    assign pending = r_pending_q;
    assign cur_div = r_cur_div_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_clock_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_clock_divider
// Description : Directed self-checking bench for prog_clock_divider.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_clock_divider;

    localparam int unsigned CNT_WIDTH = 16;

    logic                 clk_in = 1'b0;
    logic                 rst;
    logic                 en;
    logic                 en2;
    logic [CNT_WIDTH-1:0] div_in;
    logic                 div_load;
    logic [CNT_WIDTH-1:0] div_in2;
    logic                 div_load2;
    logic                 sync;

    logic                 clk_out, tick, div_ack, pending;
    logic [CNT_WIDTH-1:0] cur_div;
    logic                 clk_out2, tick2, div_ack2, pending2;
    logic [CNT_WIDTH-1:0] cur_div2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_in = ~clk_in;

    prog_clock_divider #(
        .CNT_WIDTH   (CNT_WIDTH),
        .DEFAULT_DIV (2)
    ) u_dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .en       (en),
        .div_in   (div_in),
        .div_load (div_load),
        .sync     (sync),
        .clk_out  (clk_out),
        .tick     (tick),
        .div_ack  (div_ack),
        .pending  (pending),
        .cur_div  (cur_div)
    );

    prog_clock_divider #(
        .CNT_WIDTH   (CNT_WIDTH),
        .DEFAULT_DIV (6)
    ) u_dut2 (
        .clk_in   (clk_in),
        .rst      (rst),
        .en       (en2),
        .div_in   (div_in2),
        .div_load (div_load2),
        .sync     (sync),
        .clk_out  (clk_out2),
        .tick     (tick2),
        .div_ack  (div_ack2),
        .pending  (pending2),
        .cur_div  (cur_div2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        int p;
        rst = 1'b1; en = 1'b0; en2 = 1'b0; sync = 1'b0;
        div_in = '0; div_load = 1'b0; div_in2 = '0; div_load2 = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_clk_out", 32'(clk_out), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_div_ack", 32'(div_ack), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_cur_div", 32'(cur_div), 2);
        chk("rst_cur_div2", 32'(cur_div2), 6);

        // Default divisor 2: first enabled edge starts a period
        rst = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("n2_clk", 32'(clk_out), (i % 2 == 0) ? 1 : 0);
            chk("n2_tick", 32'(tick), (i % 2 == 0) ? 1 : 0);
        end
        chk("n2_cur_div", 32'(cur_div), 2);

        // Load 5 mid-period, applied at the next start
        step();
        div_in = 5; div_load = 1'b1;
        step();
        div_load = 1'b0;
        chk("l5_pending", 32'(pending), 1);
        chk("l5_cur_div_old", 32'(cur_div), 2);
        chk("l5_tick_mid", 32'(tick), 0);
        step();
        chk("l5_ack", 32'(div_ack), 1);
        chk("l5_cur_div", 32'(cur_div), 5);
        chk("l5_pending_clr", 32'(pending), 0);
        chk("l5_tick", 32'(tick), 1);
        chk("l5_clk", 32'(clk_out), 1);
        for (int i = 0; i < 10; i++) begin
            step();
            p = (i + 1) % 5;
            chk("n5_clk", 32'(clk_out), (p < 2) ? 1 : 0);
            chk("n5_tick", 32'(tick), (p == 0) ? 1 : 0);
            chk("n5_ack", 32'(div_ack), 0);
        end

        // Loads of 7 then 3 before the boundary: last one wins
        div_in = 7; div_load = 1'b1;
        step();
        div_in = 3;
        step();
        div_load = 1'b0;
        step();
        chk("l73_pending", 32'(pending), 1);
        chk("l73_cur_div_old", 32'(cur_div), 5);
        step();
        step();
        chk("l73_ack", 32'(div_ack), 1);
        chk("l73_cur_div", 32'(cur_div), 3);
        chk("l73_tick", 32'(tick), 1);
        for (int i = 0; i < 6; i++) begin
            step();
            p = (i + 1) % 3;
            chk("n3_clk", 32'(clk_out), (p == 0) ? 1 : 0);
            chk("n3_tick", 32'(tick), (p == 0) ? 1 : 0);
            chk("n3_ack", 32'(div_ack), 0);
        end

        // N=4 then freeze in the high phase
        div_in = 4; div_load = 1'b1;
        step();
        div_load = 1'b0;
        step();
        step();
        chk("l4_cur_div", 32'(cur_div), 4);
        chk("l4_tick", 32'(tick), 1);
        chk("l4_clk", 32'(clk_out), 1);
        step();
        chk("n4_pos1_clk", 32'(clk_out), 1);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("frz_clk", 32'(clk_out), 1);
            chk("frz_tick", 32'(tick), 0);
        end
        en = 1'b1;
        step();
        chk("res_pos2_clk", 32'(clk_out), 0);
        chk("res_pos2_tick", 32'(tick), 0);
        step();
        chk("res_pos3_clk", 32'(clk_out), 0);
        step();
        chk("res_pos0_tick", 32'(tick), 1);
        chk("res_pos0_clk", 32'(clk_out), 1);

        // Load 0: divider goes idle at the boundary
        div_in = 0; div_load = 1'b1;
        step();
        div_load = 1'b0;
        step();
        step();
        step();
        chk("l0_ack", 32'(div_ack), 1);
        chk("l0_cur_div", 32'(cur_div), 0);
        chk("l0_clk", 32'(clk_out), 0);
        chk("l0_tick", 32'(tick), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("idle_clk", 32'(clk_out), 0);
            chk("idle_tick", 32'(tick), 0);
        end

        // Load 1 from idle: bypass, tick every cycle
        div_in = 1; div_load = 1'b1;
        step();
        div_load = 1'b0;
        chk("l1_pending", 32'(pending), 1);
        chk("l1_tick_wait", 32'(tick), 0);
        step();
        chk("l1_ack", 32'(div_ack), 1);
        chk("l1_cur_div", 32'(cur_div), 1);
        chk("l1_tick", 32'(tick), 1);
        chk("l1_clk", 32'(clk_out), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("n1_tick", 32'(tick), 1);
            chk("n1_clk", 32'(clk_out), 1);
            chk("n1_ack", 32'(div_ack), 0);
        end

        // Two dividers at N=6, offset by two cycles, re-phased by sync
        div_in = 6; div_load = 1'b1;
        step();
        div_load = 1'b0;
        step();
        chk("l6_cur_div", 32'(cur_div), 6);
        chk("l6_tick", 32'(tick), 1);
        step();
        en2 = 1'b1;
        step();
        chk("off_tick2", 32'(tick2), 1);
        chk("off_tick1", 32'(tick), 0);
        step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("sync_tick1", 32'(tick), 1);
        chk("sync_tick2", 32'(tick2), 1);
        for (int i = 0; i < 12; i++) begin
            step();
            p = (i + 1) % 6;
            chk("n6_tick1", 32'(tick), (p == 0) ? 1 : 0);
            chk("n6_tick2", 32'(tick2), (p == 0) ? 1 : 0);
            chk("n6_clk1", 32'(clk_out), (p < 3) ? 1 : 0);
            chk("n6_clk2", 32'(clk_out2), (p < 3) ? 1 : 0);
        end

        // Reset mid-period with a pending load
        step();
        div_in = 9; div_load = 1'b1;
        step();
        div_load = 1'b0;
        chk("prst_pending", 32'(pending), 1);
        chk("prst_clk_hi", 32'(clk_out), 1);
        rst = 1'b1;
        step();
        chk("mrst_clk_out", 32'(clk_out), 0);
        chk("mrst_tick", 32'(tick), 0);
        chk("mrst_div_ack", 32'(div_ack), 0);
        chk("mrst_pending", 32'(pending), 0);
        chk("mrst_cur_div", 32'(cur_div), 2);
        chk("mrst_cur_div2", 32'(cur_div2), 6);
        rst = 1'b0;
        step();
        chk("post_rst_tick", 32'(tick), 1);
        chk("post_rst_cur_div", 32'(cur_div), 2);
        chk("post_rst_pending", 32'(pending), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
